// File: rtl/lsu.sv
// lsu -- load/store unit for the memory stage of the single-cycle core.
//
// Accepts one memory operation at a time from the core, checks it for
// alignment and funct3 legality, and performs a single access on a
// valid/ready memory port. Loads return sign- or zero-extended data.
// Stores return an acknowledgement with zero data. An access that stalls
// too long in REQ+WAIT is abandoned with an error.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    core request handshake (req_ready = ~busy)
//   req_we, req_funct3       store select and RV32I funct3
//   req_addr, req_wdata      effective address and store data (rs2)
//   mem_valid / mem_ready    memory request handshake
//   mem_addr, mem_we         word-aligned address and write enable
//   mem_wstrb, mem_wdata     byte strobes and lane-replicated store data
//   mem_rvalid, mem_rdata    read data / store completion from memory
//   resp_valid               one-cycle completion pulse to writeback
//   resp_rdata, resp_err     extended load data, error flag
//   busy                     unit is not idle; the core stalls on it
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [8:0]  cnt_inc;
  logic        timed_out;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (we && f3[2]) bad = 1'b1;
    if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return rdata;
    endcase
  endfunction

  // cnt_inc equals the 1-based index of the current cycle spent in REQ+WAIT.
  assign cnt_inc   = {1'b0, cnt} + 9'd1;
  assign timed_out = (cnt_inc >= 9'(TIMEOUT_CYCLES));

  // All outputs below come from state alone, so reset drops them at once.
  assign busy       = (state != IDLE);
  assign req_ready  = ~busy;
  assign mem_valid  = (state == REQ);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      mem_addr   <= 32'd0;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt        <= 8'd0;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_we     <= req_we;
            mem_wstrb  <= req_we ? store_strb(req_funct3, req_addr[1:0]) : 4'd0;
            mem_wdata  <= req_we ? store_data(req_funct3, req_wdata) : 32'd0;
            resp_rdata <= 32'd0;
            if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt_inc[7:0];
          // A handshake in the limit cycle still counts as progress.
          if (mem_ready) begin
            state <= WAIT;
          end else if (timed_out) begin
            resp_err <= 1'b1;
            state    <= RESP;
          end
        end
        WAIT: begin
          cnt <= cnt_inc[7:0];
          if (mem_rvalid) begin
            resp_rdata <= mem_we ? 32'd0 : load_ext(funct3_q, off_q, mem_rdata);
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if (timed_out) begin
            resp_err <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Memory-side expectations and behaviour for the transaction in flight.
  logic        m_legal = 1'b1;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [3:0]  m_strb = 4'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  int          rd_left = 0;
  int          wv = 0;
  int          m_dv = 0;
  bit          pend = 1'b0;
  bit          m_never = 1'b0;
  bit          inj = 1'b0;
  bit          saw_mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: legality by natural alignment, lanes by byte position,
  // loads assembled little-endian from a byte view of the word.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic legal,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] ld);
    int o;
    int size;
    longint v;
    o = int'(addr[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && !(we && (f3 == 3'd4 || f3 == 3'd5))
            && ((o % size) == 0);
    strb = 4'd0;
    wd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      strb[i] = we && (i >= o) && (i < o + size);
      wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    v = 0;
    for (int k = 0; k < size && (o + k) < 4; k++)
      v = v | (longint'(rdata[8*(o+k) +: 8]) << (8*k));
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
      v = v - (longint'(1) << (8*size));
    ld = we ? 32'd0 : v[31:0];
  endfunction

  task automatic mem_step();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (inj) begin
      mem_rvalid = 1'b1;
      inj = 1'b0;
    end else if (mem_valid) begin
      saw_mvalid = 1'b1;
      chk1("mem_valid_legal", 1'b1, m_legal);
      chk("mem_addr", mem_addr, m_addr);
      chk1("mem_we", mem_we, m_we);
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_strb});
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      if (rd_left > 0) rd_left--;
      else begin
        mem_ready = 1'b1;
        pend = 1'b1;
        wv = m_dv;
      end
    end else if (pend && !m_never) begin
      if (wv > 0) wv--;
      else begin
        mem_rvalid = 1'b1;
        mem_rdata  = m_rdata;
        pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
  endtask

  task automatic start_tx(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int dr, input int dv, input bit never);
    logic legal;
    logic [3:0] strb;
    logic [31:0] wd;
    logic [31:0] ld;
    exp_t e;
    int h;
    int r;
    int lim;
    model(we, f3, addr, wdata, rdata, legal, strb, wd, ld);
    m_legal = legal; m_we = we; m_addr = {addr[31:2], 2'b00}; m_strb = strb;
    m_wdata = wd; m_rdata = rdata; rd_left = dr; m_dv = dv; m_never = never;
    pend = 1'b0; saw_mvalid = 1'b0;
    h = 1 + dr;
    r = h + 1 + dv;
    lim = (TO > h + 1) ? TO : h + 1;
    if (!legal) begin
      e.at = cyc + 1; e.err = 1'b1; e.rdata = 32'd0;
    end else if (h > TO) begin
      e.at = cyc + TO + 1; e.err = 1'b1; e.rdata = 32'd0;
    end else if (!never && r <= lim) begin
      e.at = cyc + r + 1; e.err = 1'b0; e.rdata = ld;
    end else begin
      e.at = cyc + lim + 1; e.err = 1'b1; e.rdata = 32'd0;
    end
    chk1("req_ready_idle", req_ready, 1'b1);
    sbq.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 40) begin
      tick();
      i++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_wait: busy still 1 after %0d cycles", i);
    end
  endtask

  task automatic run_tx(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int dr, input int dv, input bit never);
    start_tx(we, f3, addr, wdata, rdata, dr, dv, never);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk1("rst_resp_err", resp_err, 1'b0);
  endtask

  // Scoreboard monitor: consumes one expectation per observed response.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_cycle", cyc, mon_e.at);
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk1("resp_err", resp_err, mon_e.err);
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_resp: no resp_valid at cycle %0d, expected at %0d", cyc, sbq[0].at);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs();
    tick();

    // Byte loads at the top lane, signed and unsigned.
    run_tx(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h8000_0000, 0, 0, 1'b0);
    run_tx(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h8000_0000, 0, 0, 1'b0);

    // Halfword store with a four-cycle ready stall.
    run_tx(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 4, 0, 1'b0);

    // Illegal requests never reach memory.
    run_tx(1'b0, 3'b010, 32'h0000_3002, 32'd0, 32'd0, 0, 0, 1'b0);
    chk1("illegal_lw_no_mem_valid", saw_mvalid, 1'b0);
    run_tx(1'b1, 3'b100, 32'h0000_3000, 32'hCAFE_F00D, 32'd0, 0, 0, 1'b0);
    chk1("illegal_store_no_mem_valid", saw_mvalid, 1'b0);

    // Timeout with no read data, then a stray rvalid while idle.
    run_tx(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'd0, 0, 0, 1'b1);
    inj = 1'b1;
    tick();
    tick();
    chk1("late_rvalid_no_resp", resp_valid, 1'b0);
    tick();
    chk1("late_rvalid_no_resp2", resp_valid, 1'b0);
    chk1("late_rvalid_idle", busy, 1'b0);

    // Read data arriving in the very cycle the timeout limit is reached.
    run_tx(1'b0, 3'b101, 32'h0000_4002, 32'd0, 32'hBEEF_0000, 0, TO - 2, 1'b0);

    // Reset while waiting for read data.
    start_tx(1'b0, 3'b010, 32'h0000_7000, 32'd0, 32'h1111_2222, 0, 5, 1'b0);
    tick();
    chk1("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    sbq.delete();
    pend = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_tx(1'b1, 3'b010, 32'h0000_6000, 32'h89AB_CDEF, 32'd0, 1, 1, 1'b0);

    // Randomized traffic within the timeout window.
    for (int n = 0; n < 60; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rf3[1:0] == 2'b01) raddr[0] = 1'b0;
        if (rf3[1:0] == 2'b10) raddr[1:0] = 2'b00;
      end
      run_tx(rwe, rf3, raddr, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    tick();
    tick();
    chk("sbq_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the single-cycle core's memory stage. It takes the effective address computed by the ALU's adder output together with rs2 data and the instruction's funct3, performs one access on a valid/ready memory port, and returns extracted, sign- or zero-extended load data, or a store acknowledgement, to writeback. The core stalls on `busy`. The unit has one access outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in REQ+WAIT before the access is abandoned with an error. Legal range 1..255; the counter is 8 bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: the core presents a memory op.
- `req_ready` out 1: the LSU can accept; equals `~busy`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- `req_addr` in 32: effective address (ALU sum).
- `req_wdata` in 32: store data (rs2).
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts the request.
- `mem_addr` out 32: word-aligned address, {addr[31:2], 2'b00}.
- `mem_we` out 1: write enable.
- `mem_wstrb` out 4: byte-lane strobes. All zero for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: read data valid, or store completion.
- `mem_rdata` in 32: read word.
- `resp_valid` out 1: single-cycle completion pulse.
- `resp_rdata` out 32: extended load data. Zero for stores and for errors.
- `resp_err` out 1: misaligned access, illegal funct3, or timeout. Valid only with `resp_valid`.
- `busy` out 1: the state is not IDLE.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we, funct3, addr and wdata, clear the timeout counter, then classify the request.
  - Illegal requests go to RESP with err=1 and no memory access. Illegal means any of:
    - funct3 in {011, 110, 111};
    - a store with funct3 100 or 101;
    - a halfword access with addr[0]=1;
    - a word access with addr[1:0]≠0.
  - All other requests go to REQ.
- REQ:
  - `mem_valid`=1.
  - addr, we, wstrb and wdata are driven from the latched registers and held stable until `mem_ready`.
  - `mem_valid & mem_ready` moves the FSM to WAIT.
- WAIT:
  - `mem_rvalid` is sampled only in this state.
  - On `mem_rvalid`, register `resp_rdata` (extended for loads, 0 for stores) and go to RESP with err=0.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Timeout:
  - The counter increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no completing event that cycle, go to RESP with err=1 and deassert `mem_valid`.
  - If a completion and the timeout occur in the same cycle, the completion wins.
  - A late `mem_rvalid` arriving in IDLE or RESP is ignored.
- Store lanes, with o = addr[1:0]:
  - sb: strb = 0001<<o, data = {4{wdata[7:0]}}.
  - sh: strb = 0011<<o, data = {2{wdata[15:0]}}.
  - sw: strb = 1111, data = wdata.
- Load extract: s = mem_rdata >> (8*o).
  - lb: sext(s[7:0]).
  - lbu: zext(s[7:0]).
  - lh: sext(s[15:0]).
  - lhu: zext(s[15:0]).
  - lw: mem_rdata.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE and counter = 0.
  - `mem_valid`, `mem_we`, `mem_wstrb`, `mem_wdata`, `mem_addr`, `resp_valid`, `resp_rdata`, `resp_err` and `busy` are all 0.
  - `req_ready` = 1.
- Reset mid-access abandons the transaction. `mem_valid` drops without waiting for a clock.
- The accept cycle is cycle 0, the cycle in IDLE with `req_valid`=1.
- With zero-wait memory (`mem_ready`=1 in cycle 1, `mem_rvalid`=1 in cycle 2), `resp_valid` is high in cycle 3.
- An illegal request has `resp_valid` high in cycle 1.
- The earliest next accept is the cycle after RESP.
- Every added cycle of `mem_ready` or `mem_rvalid` delay adds exactly one cycle of latency.
- The memory must not assert `mem_rvalid` in the cycle it accepts the request. Such an assertion is not observed.
- All outputs are decoded from state and registers only. There is no combinational path from any input to any output.

## Test plan
- Zero-wait lb, addr=0x1003, mem_rdata=0x80_00_00_00 → `mem_addr`=0x1000, `mem_wstrb`=0000, `resp_rdata`=0xFFFFFF80, `resp_err`=0, `resp_valid` in cycle 3. Repeat as lbu → 0x00000080.
- sh, addr=0x2002, wdata=0x1234ABCD → `mem_wstrb`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1, `resp_rdata`=0. Hold `mem_ready`=0 for 4 cycles → `mem_valid` and all request fields stable throughout; `resp_valid` in cycle 7.
- lw, addr=0x3002 → `resp_err`=1 in cycle 1 and `mem_valid` never asserted. Store with funct3=100 → same result.
- `TIMEOUT_CYCLES`=4, `mem_ready` held 1, `mem_rvalid` never asserted → error response after 4 cycles in REQ+WAIT. Then a `mem_rvalid` pulse in IDLE → no `resp_valid`.
- lhu, addr=0x4002, `mem_rdata`=0xBEEF0000, `mem_rvalid` arriving in the same cycle the timeout counter reaches its limit → `resp_err`=0, `resp_rdata`=0x0000BEEF.
- Assert `rst` while in WAIT → `mem_valid`, `busy` and `resp_valid` are 0 immediately and `req_ready`=1. A new sw issued after reset completes normally with `mem_wstrb`=1111.
